// File: rtl/btn_digit_counter.sv
// Button-driven multi-digit entry: per-button sync/debounce lanes feed a pending
// queue; one press per cycle steps its digit modulo RADIX with optional ripple.

module btn_digit_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_vld,
  input  logic btn,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1, s2, db, db_q, armed;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // A button held across reset must be seen released before it may press.
      if (sync_vld && !s2 && !db) armed <= 1'b1;
    end
  end

  assign press = db & ~db_q & armed;
endmodule

module btn_digit_counter #(
  parameter int DIGITS          = 4,
  parameter int DIGIT_W         = 4,
  parameter int RADIX           = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIGITS-1:0]           btn,
  input  logic                        dir,
  input  logic                        carry_en,
  input  logic                        clr,
  input  logic                        load,
  input  logic [DIGITS*DIGIT_W-1:0]   load_val,
  output logic [DIGITS*DIGIT_W-1:0]   num,
  output logic                        step,
  output logic                        wrap
);
  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(RADIX - 1);

  logic [1:0]                      vld_pipe;
  logic [DIGITS-1:0]               press, pending, sel;
  logic [DIGITS-1:0][DIGIT_W-1:0]  dig_q, dig_nxt, ld_dig;
  logic                            wrap_nxt;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lane
      btn_digit_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .sync_vld (vld_pipe[1]),
        .btn      (btn[gi]),
        .press    (press[gi])
      );
      assign ld_dig[gi] = ({1'b0, load_val[gi*DIGIT_W +: DIGIT_W]} < (DIGIT_W+1)'(RADIX))
                        ? load_val[gi*DIGIT_W +: DIGIT_W] : '0;
    end
  endgenerate

  // Lowest pending bit wins.
  assign sel = pending & (~pending + DIGITS'(1));

  always_comb begin
    logic c, h, at_edge;
    c       = 1'b0;
    h       = 1'b0;
    at_edge = 1'b0;
    dig_nxt = dig_q;
    for (int j = 0; j < DIGITS; j++) begin
      h       = sel[j] | c;
      at_edge = dir ? (dig_q[j] == '0) : (dig_q[j] == DMAX);
      if (h) begin
        if (dir) dig_nxt[j] = at_edge ? DMAX : dig_q[j] - DIGIT_W'(1);
        else     dig_nxt[j] = at_edge ? '0   : dig_q[j] + DIGIT_W'(1);
      end
      c = carry_en & h & at_edge;
    end
    wrap_nxt = c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      pending  <= '0;
      dig_q    <= '0;
      step     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], 1'b1};
      if (clr) begin
        pending <= '0;
        dig_q   <= '0;
        step    <= 1'b0;
        wrap    <= 1'b0;
      end else if (load) begin
        pending <= '0;
        dig_q   <= ld_dig;
        step    <= 1'b0;
        wrap    <= 1'b0;
      end else begin
        pending <= (pending & ~sel) | press;
        dig_q   <= dig_nxt;
        step    <= |pending;
        wrap    <= wrap_nxt;
      end
    end
  end

  assign num = dig_q;
endmodule

// File: tb/tb_btn_digit_counter.sv
// Directed bench: hex (RADIX 16) and BCD (RADIX 10) instances share stimulus,
// DEBOUNCE_CYCLES=4 so a held button steps 7 edges after it is first sampled.

module tb_btn_digit_counter;
  logic        clk = 1'b0;
  logic        rst, dir, carry_en, clr, load;
  logic [3:0]  btn;
  logic [15:0] load_val;
  logic [15:0] num, num10;
  logic        step, wrap, step10, wrap10;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  btn_digit_counter #(.DIGITS(4), .DIGIT_W(4), .RADIX(16), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn(btn), .dir(dir), .carry_en(carry_en), .clr(clr),
    .load(load), .load_val(load_val), .num(num), .step(step), .wrap(wrap));

  btn_digit_counter #(.DIGITS(4), .DIGIT_W(4), .RADIX(10), .DEBOUNCE_CYCLES(4)) dut10 (
    .clk(clk), .rst(rst), .btn(btn), .dir(dir), .carry_en(carry_en), .clr(clr),
    .load(load), .load_val(load_val), .num(num10), .step(step10), .wrap(wrap10));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hold mask for 'hold' edges then release for 'rel' edges; index 0 is the
  // first edge that samples the button high.
  task automatic press(input logic [3:0] m, input int hold, input int rel,
                       output int first, output int ns, output int nw, output int nw10);
    first = -1; ns = 0; nw = 0; nw10 = 0;
    btn = m;
    for (int i = 0; i < hold + rel; i++) begin
      if (i == hold) btn = 4'b0;
      tick;
      if (step) begin
        if (first < 0) first = i;
        ns++;
      end
      if (wrap)   nw++;
      if (wrap10) nw10++;
    end
  endtask

  task automatic pulse_clr;
    clr = 1'b1; tick; clr = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v; load = 1'b1; tick; load = 1'b0;
  endtask

  initial begin
    int first, ns, nw, nw10, nb;
    rst = 1'b1; btn = '0; dir = 1'b0; carry_en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    tick; tick;
    check("reset_num",  {16'h0, num}, 32'h0);
    check("reset_step", {31'h0, step}, 32'h0);
    check("reset_wrap", {31'h0, wrap}, 32'h0);
    rst = 1'b0;
    repeat (4) tick;

    // Basic press, latency and single step
    press(4'b0001, 20, 12, first, ns, nw, nw10);
    check("press1_latency", first, 7);
    check("press1_count",   ns, 1);
    check("press1_num",     {16'h0, num}, 32'h0001);
    press(4'b0001, 20, 12, first, ns, nw, nw10);
    check("press2_num",     {16'h0, num}, 32'h0002);

    // Bounce on btn[1]
    pulse_clr;
    check("clr_num", {16'h0, num}, 32'h0);
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      btn = ((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      tick;
      if (step) nb++;
    end
    press(4'b0010, 20, 12, first, ns, nw, nw10);
    check("bounce_count", nb + ns, 1);
    check("bounce_num",   {16'h0, num}, 32'h0010);

    // BCD carry ripple
    carry_en = 1'b1;
    do_load(16'h0999);
    check("bcd_load", {16'h0, num10}, 32'h0999);
    press(4'b0001, 20, 12, first, ns, nw, nw10);
    check("bcd_carry_num",  {16'h0, num10}, 32'h1000);
    check("bcd_carry_wrap", nw10, 0);
    check("hex_carry_num",  {16'h0, num}, 32'h099A);
    do_load(16'h9999);
    press(4'b0001, 20, 12, first, ns, nw, nw10);
    check("bcd_wrap_num",   {16'h0, num10}, 32'h0000);
    check("bcd_wrap_pulse", nw10, 1);
    check("hex_nowrap",     nw, 0);

    // Decrement borrow
    dir = 1'b1;
    pulse_clr;
    press(4'b0001, 20, 12, first, ns, nw, nw10);
    check("dec_borrow_num",  {16'h0, num}, 32'hFFFF);
    check("dec_borrow_wrap", nw, 1);
    check("dec_bcd_num",     {16'h0, num10}, 32'h9999);
    carry_en = 1'b0;
    pulse_clr;
    press(4'b0001, 20, 12, first, ns, nw, nw10);
    check("dec_nocarry_num",  {16'h0, num}, 32'h000F);
    check("dec_nocarry_wrap", nw, 0);
    check("dec_nocarry_bcd",  {16'h0, num10}, 32'h0009);

    // Simultaneous presses are applied on consecutive cycles, lowest first
    dir = 1'b0; carry_en = 1'b1;
    pulse_clr;
    btn = 4'b0101;
    repeat (7) tick;
    check("sim_pre_step", {31'h0, step}, 32'h0);
    tick;
    check("sim_T_step", {31'h0, step}, 32'h1);
    check("sim_T_num",  {16'h0, num}, 32'h0001);
    tick;
    check("sim_T1_step", {31'h0, step}, 32'h1);
    check("sim_T1_num",  {16'h0, num}, 32'h0101);
    btn = 4'b0;
    repeat (12) tick;

    // clr at T wins over the step and empties the queue
    pulse_clr;
    btn = 4'b0101;
    repeat (7) tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    check("clrT_num",  {16'h0, num}, 32'h0);
    check("clrT_step", {31'h0, step}, 32'h0);
    tick;
    check("clrT1_step", {31'h0, step}, 32'h0);
    check("clrT1_num",  {16'h0, num}, 32'h0);
    btn = 4'b0;
    repeat (12) tick;

    // Reset mid-debounce with the button still held
    btn = 4'b1000;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_mid_num", {16'h0, num}, 32'h0);
    press(4'b1000, 20, 12, first, ns, nw, nw10);
    check("rst_held_steps", ns, 0);
    check("rst_held_num",   {16'h0, num}, 32'h0);
    press(4'b1000, 20, 12, first, ns, nw, nw10);
    check("rst_repress_steps", ns, 1);
    check("rst_repress_num",   {16'h0, num}, 32'h1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
